// File: rtl/objects_mux_pkg.sv
// Shared types and helpers for the layered object mux.
// The RGB332 color type, the default see-through key, and the 24-bit color expansion.
package objects_mux_pkg;

  typedef logic [7:0] rgb332_t;

  localparam rgb332_t DEFAULT_TRANSPARENT_KEY = 8'hFF;

  // Each channel is widened by repeating the LSB of its field.
  function automatic logic [23:0] expand_rgb332(input rgb332_t c);
    return {c[7:5], {5{c[5]}}, c[4:2], {5{c[2]}}, c[1:0], {6{c[0]}}};
  endfunction

endpackage

// File: rtl/objects_mux_prio_enc.sv
// Combinational lowest-index-first priority encoder.
// When no input is set, idx_o reports N, which is the background index.
module objects_mux_prio_enc #(
  parameter int N = 16
) (
  input  logic [N-1:0]              valid_i,
  output logic [$clog2(N+1)-1:0]    idx_o,
  output logic                      any_o
);

  localparam int IW = $clog2(N + 1);

  always_comb begin
    idx_o = IW'(N);
    any_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        idx_o = IW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/objects_mux_layered.sv
// Two-stage layered object mux: the lowest-index visible layer wins, otherwise the background.
// Optional per-layer blinking is compiled in with OBJ_MUX_BLINK_EN.
module objects_mux_layered
  import objects_mux_pkg::*;
#(
  parameter int      NUM_LAYERS      = 16,
  parameter rgb332_t TRANSPARENT_KEY = DEFAULT_TRANSPARENT_KEY,
  parameter int      BLINK_FRAMES    = 30
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              startOfFrame,
  input  logic [NUM_LAYERS-1:0]             layerReq,
  input  logic [NUM_LAYERS*8-1:0]           layerRGB,
  input  logic [NUM_LAYERS-1:0]             layerEnable,
  input  logic [NUM_LAYERS-1:0]             blinkMask,
  input  logic [7:0]                        backGroundRGB,
  output logic [7:0]                        redOut,
  output logic [7:0]                        greenOut,
  output logic [7:0]                        blueOut,
  output logic [$clog2(NUM_LAYERS+1)-1:0]   winLayer
);

  localparam int WIW = $clog2(NUM_LAYERS + 1);

  // The next-state of the shadow registers doubles as the value seen by the
  // current pixel, so the start-of-frame pixel already uses the new settings.
  logic [NUM_LAYERS-1:0] shadow_en_q, shadow_en_d;
  logic [NUM_LAYERS-1:0] blink_hide;

  always_comb begin
    shadow_en_d = startOfFrame ? layerEnable : shadow_en_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) shadow_en_q <= '1;
    else         shadow_en_q <= shadow_en_d;
  end

`ifdef OBJ_MUX_BLINK_EN
  logic [NUM_LAYERS-1:0] shadow_blk_q, shadow_blk_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic                  blink_on_q, blink_on_d;

  always_comb begin
    shadow_blk_d = shadow_blk_q;
    frame_cnt_d  = frame_cnt_q;
    blink_on_d   = blink_on_q;
    if (startOfFrame) begin
      shadow_blk_d = blinkMask;
      if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = 8'h00;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shadow_blk_q <= '0;
      frame_cnt_q  <= 8'h00;
      blink_on_q   <= 1'b0;
    end else begin
      shadow_blk_q <= shadow_blk_d;
      frame_cnt_q  <= frame_cnt_d;
      blink_on_q   <= blink_on_d;
    end
  end

  assign blink_hide = blink_on_d ? shadow_blk_d : '0;
`else
  logic unused_blink_cfg;
  assign unused_blink_cfg = ^{blinkMask, 8'(BLINK_FRAMES)};
  assign blink_hide       = '0;
`endif

  logic [NUM_LAYERS-1:0] valid_d;

  generate
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_valid
      assign valid_d[gi] = layerReq[gi] & shadow_en_d[gi] & ~blink_hide[gi]
                         & (layerRGB[8*gi +: 8] != TRANSPARENT_KEY);
    end
  endgenerate

  logic [NUM_LAYERS-1:0]   valid_s1_q;
  logic [NUM_LAYERS*8-1:0] rgb_s1_q;
  rgb332_t                 bg_s1_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid_s1_q <= '0;
      rgb_s1_q   <= '0;
      bg_s1_q    <= 8'h00;
    end else begin
      valid_s1_q <= valid_d;
      rgb_s1_q   <= layerRGB;
      bg_s1_q    <= backGroundRGB;
    end
  end

  logic [WIW-1:0] enc_idx;
  logic           enc_any;

  objects_mux_prio_enc #(
    .N (NUM_LAYERS)
  ) u_prio_enc (
    .valid_i (valid_s1_q),
    .idx_o   (enc_idx),
    .any_o   (enc_any)
  );

  rgb332_t        sel_rgb;
  rgb332_t        color_s2_d, color_s2_q;
  logic [WIW-1:0] win_s2_d, win_s2_q;

  always_comb begin
    sel_rgb = 8'h00;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (enc_idx == WIW'(i)) sel_rgb = rgb_s1_q[8*i +: 8];
    end
    color_s2_d = enc_any ? sel_rgb : bg_s1_q;
    win_s2_d   = enc_idx;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      color_s2_q <= 8'h00;
      win_s2_q   <= WIW'(NUM_LAYERS);
    end else begin
      color_s2_q <= color_s2_d;
      win_s2_q   <= win_s2_d;
    end
  end

  assign {redOut, greenOut, blueOut} = expand_rgb332(color_s2_q);
  assign winLayer                    = win_s2_q;

endmodule

// File: tb/tb_objects_mux_layered.sv
// Randomized scoreboard bench for objects_mux_layered with a frame-level reference model.
// Blink expectations follow OBJ_MUX_BLINK_EN when it is defined for the build.
module tb_objects_mux_layered;

  localparam int NL  = 16;
  localparam int BF  = 2;
  localparam int WIW = $clog2(NL + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                resetN = 1'b1;
  logic                sof    = 1'b0;
  logic [NL-1:0]       req    = '0;
  logic [NL*8-1:0]     rgb    = '1;
  logic [NL-1:0]       en     = '1;
  logic [NL-1:0]       blk    = '0;
  logic [7:0]          bg     = 8'h00;
  logic [7:0]          r_o, g_o, b_o;
  logic [WIW-1:0]      win_o;

  objects_mux_layered #(
    .NUM_LAYERS      (NL),
    .TRANSPARENT_KEY (8'hFF),
    .BLINK_FRAMES    (BF)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (sof),
    .layerReq      (req),
    .layerRGB      (rgb),
    .layerEnable   (en),
    .blinkMask     (blk),
    .backGroundRGB (bg),
    .redOut        (r_o),
    .greenOut      (g_o),
    .blueOut       (b_o),
    .winLayer      (win_o)
  );

  typedef struct {
    int          due;
    int          win;
    logic [23:0] rgb;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model state: frame-level settings and number of frames since reset.
  logic [NL-1:0] m_en   = '1;
  logic [NL-1:0] m_blk  = '0;
  int            m_sofs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] expand(input logic [7:0] c);
    return {c[7:5], {5{c[5]}}, c[4:2], {5{c[2]}}, c[1:0], {6{c[0]}}};
  endfunction

  task automatic check(input string tag, input int exp_win, input logic [23:0] exp_rgb);
    n_vec++;
    if (win_o !== WIW'(exp_win) || {r_o, g_o, b_o} !== exp_rgb) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got win=%0d rgb=%06h, want win=%0d rgb=%06h",
               tag, cyc, win_o, {r_o, g_o, b_o}, exp_win, exp_rgb);
    end
  endtask

  // Monitor: outputs are compared after every active edge against due entries.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        if (e.due < cyc) begin
          n_vec++;
          n_fail++;
          $display("FAIL %s: entry due cycle %0d unchecked at %0d", e.tag, e.due, cyc);
        end else begin
          check(e.tag, e.win, e.rgb);
        end
      end
    end
  end

  task automatic push(input int lat, input int w, input logic [7:0] c, input string tag);
    exp_t e;
    e.due = cyc + lat;
    e.win = w;
    e.rgb = expand(c);
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  // Drives one pixel at a falling edge, predicts its result, then waits one cycle.
  task automatic apply(input logic s, input logic [NL-1:0] rq, input logic [NL*8-1:0] cols,
                       input logic [NL-1:0] e, input logic [NL-1:0] bm, input logic [7:0] bgc,
                       input string tag);
    int         w;
    logic [7:0] c;
    logic [7:0] ci;
    bit         blink_on;
    sof = s; req = rq; rgb = cols; en = e; blk = bm; bg = bgc;
    if (s) begin
      m_en  = e;
      m_blk = bm;
      m_sofs++;
    end
`ifdef OBJ_MUX_BLINK_EN
    blink_on = ((m_sofs / BF) % 2) == 1;
`else
    blink_on = 1'b0;
`endif
    w = NL;
    c = bgc;
    for (int i = 0; i < NL; i++) begin
      ci = cols[8*i +: 8];
      if (rq[i] && m_en[i] && ci != 8'hFF && !(blink_on && m_blk[i])) begin
        w = i;
        c = ci;
        break;
      end
    end
    push(2, w, c, tag);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n, input string tag);
    resetN = 1'b0;
    sb_q.delete();
    #1;
    check({tag, "_now"}, NL, 24'h000000);
    m_en   = '1;
    m_blk  = '0;
    m_sofs = 0;
    repeat (n) begin
      push(1, NL, 8'h00, tag);
      @(negedge clk);
    end
    resetN = 1'b1;
    push(1, NL, 8'h00, {tag, "_rel"});
  endtask

  task automatic rand_pixel(input int sof_den, input string tag);
    logic [NL*8-1:0] cv;
    for (int i = 0; i < NL; i++)
      cv[8*i +: 8] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
    apply($urandom_range(0, sof_den - 1) == 0,
          NL'($urandom & $urandom),
          cv,
          NL'(~($urandom & $urandom & $urandom)),
          NL'($urandom),
          ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom),
          tag);
  endtask

  initial begin
    logic [NL*8-1:0] cv;
    logic [NL-1:0]   en_no2;
    @(negedge clk);
    do_reset(3, "rst_init");

    cv = '0;
    cv[3*8 +: 8] = 8'h1C;
    cv[7*8 +: 8] = 8'hE0;
    apply(1'b1, NL'(16'h0088), cv, '1, '0, 8'h00, "l3_over_l7");

    cv = '0;
    cv[0*8 +: 8] = 8'hFF;
    cv[5*8 +: 8] = 8'h03;
    apply(1'b0, NL'(16'h0021), cv, '1, '0, 8'h00, "key_skips_l0");

    cv = '1;
    apply(1'b0, '0, cv, '1, '0, 8'hFF, "bg_is_key");

    cv = '0;
    cv[2*8 +: 8] = 8'h1C;
    cv[9*8 +: 8] = 8'hE0;
    en_no2 = '1;
    en_no2[2] = 1'b0;
    apply(1'b1, NL'(16'h0204), cv, '1, '0, 8'h00, "en_sof");
    for (int p = 0; p < 4; p++)
      apply(1'b0, NL'(16'h0204), cv, en_no2, '0, 8'h00, "en_midframe");
    apply(1'b1, NL'(16'h0204), cv, en_no2, '0, 8'h00, "en_next_sof");
    apply(1'b0, NL'(16'h0004), cv, '1, '0, 8'h5A, "en_l2_only");

    do_reset(2, "rst_blink");
    cv = '0;
    cv[1*8 +: 8] = 8'h1C;
    for (int f = 1; f <= 7; f++)
      for (int p = 0; p < 3; p++)
        apply(p == 0, NL'(16'h0002), cv, '1, NL'(16'h0002), 8'h00, $sformatf("blink_f%0d", f));

    for (int k = 0; k < 400; k++) rand_pixel(12, "rand");

    for (int k = 0; k < 20; k++) rand_pixel(6, "pre_rst");
    do_reset(2, "rst_mid");
    for (int k = 0; k < 80; k++) rand_pixel(10, "post_rst");

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/objects_mux_layered.md
OBJECTS_MUX_LAYERED -- requirements
Module: objects_mux_layered

Interface
REQ-001 The block SHALL have parameter NUM_LAYERS, default 16, number of object layers (2..32); layer 0 is the highest priority.
REQ-002 The block SHALL have parameter TRANSPARENT_KEY, default 8'hFF, the RGB332 value treated as see-through.
REQ-003 The block SHALL have parameter BLINK_FRAMES, default 30, the number of frames per blink half-period (1..255).
REQ-004 clk  in  1  pixel clock.
REQ-005 resetN  in  1  reset, asynchronous, active-low.
REQ-006 startOfFrame  in  1  single-cycle pulse at the first pixel of each frame.
REQ-007 layerReq  in  NUM_LAYERS  per-layer drawing request.
REQ-008 layerRGB  in  NUM_LAYERS x 8  per-layer RGB332 color; layer i occupies bits [8i+7:8i].
REQ-009 layerEnable  in  NUM_LAYERS  per-layer enable, applied at frame boundary only.
REQ-010 blinkMask  in  NUM_LAYERS  layers subject to blinking, applied at frame boundary only.
REQ-011 backGroundRGB  in  8  fallback color when no layer wins.
REQ-012 redOut, greenOut, blueOut  out  8 each  expanded 24-bit color.
REQ-013 winLayer  out  $clog2(NUM_LAYERS+1)  index of the winning layer; the value NUM_LAYERS means background.

Function
REQ-014 Layer i SHALL be valid when all of the following hold: layerReq[i]=1, the shadow enable[i]=1, layerRGB[i]!=TRANSPARENT_KEY, and not (blinkOn and shadow blink[i]).
REQ-015 The winner SHALL be the lowest-index valid layer; when no layer is valid, the background SHALL win.
REQ-016 Stage 1 SHALL register the valid vector and layerRGB; stage 2 SHALL register the winning color and winLayer.
REQ-017 Total latency from inputs to outputs SHALL be exactly 2 clk cycles, fully pipelined with one pixel accepted per cycle and no stalls.
REQ-018 The outputs SHALL be expanded from the stage-2 color c as follows: redOut={c[7:5],{5{c[5]}}}, greenOut={c[4:2],{5{c[2]}}}, blueOut={c[1:0],{6{c[0]}}}.
REQ-019 The shadow enable and shadow blink registers SHALL load layerEnable and blinkMask on the cycle startOfFrame=1 and hold their values otherwise.
REQ-020 The pixel presented with startOfFrame SHALL already use the newly loaded shadow values.
REQ-021 backGroundRGB SHALL be used even when it equals TRANSPARENT_KEY.
REQ-022 A change to layerEnable or blinkMask mid-frame SHALL have no visible effect until the next startOfFrame.

Reset
REQ-023 While resetN=0, both pipeline stages SHALL clear: color=8'h00, winLayer=NUM_LAYERS, and all outputs=0.
REQ-024 While resetN=0, shadow enable SHALL be all-ones, shadow blink all-zeros, the frame counter 0, and blinkOn 0.
REQ-025 Reset asserted mid-frame SHALL take effect immediately; after release, the first valid output SHALL appear 2 cycles after the first clock edge.

Configuration
REQ-026 With OBJ_MUX_BLINK_EN defined, an 8-bit frame counter SHALL increment on each startOfFrame.
REQ-027 When the counter reaches BLINK_FRAMES-1 on a startOfFrame, it SHALL wrap to 0 and toggle blinkOn; the toggle SHALL be effective on that same startOfFrame pixel.
REQ-028 Without OBJ_MUX_BLINK_EN, the counter and blinkOn SHALL be absent, blinkOn SHALL be treated as 0, and blinkMask SHALL be ignored; the port SHALL remain present.

Structure
REQ-029 Package objects_mux_pkg SHALL hold typedef rgb332_t, constant DEFAULT_TRANSPARENT_KEY=8'hFF, and the RGB332-to-24-bit expansion function.
REQ-030 Sub-module objects_mux_prio_enc SHALL be a parametrised, combinational, lowest-index-first priority encoder over NUM_LAYERS, producing an index and an any-valid flag.

Verification
REQ-031 Layers 3 and 7 requested with colors 8'h1C and 8'hE0, all enabled -> after 2 cycles winLayer=3, redOut=8'h00, greenOut=8'hFF, blueOut=8'h00.
REQ-032 Layer 0 requested with 8'hFF and layer 5 with 8'h03 -> winLayer=5, blueOut=8'hFF.
REQ-033 No requests, backGroundRGB=8'hFF -> winLayer=NUM_LAYERS, all outputs 8'hFF.
REQ-034 layerEnable[2] cleared mid-frame while layer 2 is requested -> layer 2 keeps winning until the next startOfFrame, then loses to the next valid layer or the background.
REQ-035 OBJ_MUX_BLINK_EN defined, BLINK_FRAMES=2, blinkMask[1]=1, layer 1 always requested -> layer 1 hidden for frames 2-3, shown for frames 4-5, with the pattern repeating.
REQ-036 resetN pulsed low mid-stream with pixels in flight -> outputs 0 and winLayer=NUM_LAYERS during reset; the first post-reset pixel appears exactly 2 cycles after release.
